alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Controller that sits between the datapath control logic and the shared ALU (5-bit opcode, two 32-bit operands, 64-bit result).
- Accepts one operation request at a time through a valid/ready handshake.
- Holds the operands and opcode stable at the ALU for the op-dependent number of cycles, then captures the 64-bit result into Z high/low registers and pulses done.
- Multiply and divide get configurable multi-cycle windows; all other ops take one cycle.

Parameters:
MUL_LATENCY, 4, EXEC cycles for opcode 5'b01100 (multiply); legal range 1..63.
DIV_LATENCY, 32, EXEC cycles for opcode 5'b01101 (divide); legal range 1..63.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present; requester holds all req_* stable until accepted
req_ready  out  1  sequencer can accept; high only in IDLE
req_opcode  in  5  ALU opcode
req_a  in  32  operand A
req_b  in  32  operand B
alu_opcode  out  5  registered opcode to ALU
alu_a  out  32  registered operand A to ALU
alu_b  out  32  registered operand B to ALU
alu_z  in  64  ALU result
z_high  out  32  captured result bits 63:32
z_low  out  32  captured result bits 31:0
done  out  1  one-cycle completion pulse
busy  out  1  high in EXEC and DONE
illegal_op  out  1  last accepted opcode was illegal
div_zero  out  1  last op was a divide by zero (optional feature; otherwise tied 0)

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE, req_ready=1, busy=0, done=0, and all of the following 0: alu_opcode, alu_a, alu_b, z_high, z_low, illegal_op, div_zero, cnt (6-bit).
- States: IDLE, EXEC, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid at an edge, latch req_* into alu_*, clear illegal_op and div_zero.
  - Legal opcodes are 5'b00001..5'b01101:
    - go to EXEC with cnt = L-1.
    - L = MUL_LATENCY for 01100, DIV_LATENCY for 01101, 1 for all others.
  - Illegal opcodes (00000, 01110..11111): go to DONE, set illegal_op=1, leave z_high/z_low unchanged.
- EXEC:
  - alu_* held constant; req_valid ignored (not latched).
  - At each edge: if cnt==0, capture z_high<=alu_z[63:32] and z_low<=alu_z[31:0], then go to DONE. Otherwise cnt<=cnt-1.
  - EXEC lasts exactly L cycles.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - z_high/z_low, illegal_op and div_zero hold until the next acceptance (z also persists beyond it until the next capture).
- Timing: acceptance edge E0. For a legal op, done is high in the cycle following edge E0+L+... precisely: EXEC occupies cycles 1..L after E0, DONE is cycle L+1. For an illegal op, DONE is cycle 1.
- Back-to-back: a new request can be accepted no earlier than the cycle after DONE (IDLE cycle). Minimum op-to-op spacing is L+2 cycles.
- reset wins over every event. Reset in EXEC or DONE aborts the op, with no done pulse and z cleared to 0.
- busy = (state != IDLE). req_ready = (state == IDLE) && !reset.

Optional Feature:
- Macro: ALU_DIV_ZERO_TRAP_EN.
- Defined: on accepting opcode 01101 with req_b==0:
  - skip EXEC and go to DONE next cycle;
  - set div_zero=1 and write z_high=z_low=0;
  - the ALU result is not sampled.
- Undefined: no special case. The divide runs DIV_LATENCY cycles and captures whatever alu_z shows; the div_zero output is constant 0.

Test Plan:
- Reset, then ADD 01010, A=5, B=7, with a behavioural ALU model:
  - z_low=12, z_high=0;
  - done high in cycle 2 after acceptance, busy high cycles 1-2, req_ready low cycles 1-2.
- MUL 01100, A=32'hFFFFFFFF, B=3, MUL_LATENCY=4:
  - alu_a/alu_b stable for 4 cycles;
  - z_high=32'hFFFFFFFF, z_low=32'hFFFFFFFD;
  - done in cycle 5 only.
- Prior result z_low=12, then opcode 5'b11111:
  - illegal_op=1 and done in cycle 1;
  - z_low stays 12;
  - illegal_op clears on the next acceptance.
- DIV 01101, A=100, B=7, then reset asserted in EXEC cycle 3:
  - next cycle state IDLE, req_ready=1, z=0, done never pulses;
  - a following ADD works normally.
- DIV with B=0:
  - with ALU_DIV_ZERO_TRAP_EN: div_zero=1, z=0, done in cycle 1;
  - without it: done in cycle DIV_LATENCY+1, div_zero=0.
- req_valid held high over two queued requests (SUB 01011 then AND 00110):
  - second request accepted in the IDLE cycle right after the first done;
  - its req_* are not latched during EXEC or DONE.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Sequencer that presents a latched opcode and operands to the shared ALU for an op-dependent
// window, then captures the 64-bit result. Optional `ALU_DIV_ZERO_TRAP_EN: divide by zero traps.
module alu_op_sequencer #(
  parameter int MUL_LATENCY = 4,
  parameter int DIV_LATENCY = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_opcode,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [4:0]  alu_opcode,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [63:0] alu_z,
  output logic [31:0] z_high,
  output logic [31:0] z_low,
  output logic        done,
  output logic        busy,
  output logic        illegal_op,
  output logic        div_zero
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  localparam logic [4:0] OP_MUL  = 5'b01100;
  localparam logic [4:0] OP_DIV  = 5'b01101;
  localparam logic [5:0] MUL_CNT = 6'(MUL_LATENCY - 1);
  localparam logic [5:0] DIV_CNT = 6'(DIV_LATENCY - 1);

  state_t     state;
  logic [5:0] cnt;
  logic       legal;
  logic       dz_trap;
  logic [5:0] load_cnt;

  assign legal = (req_opcode != 5'b00000) && (req_opcode <= OP_DIV);

`ifdef ALU_DIV_ZERO_TRAP_EN
  assign dz_trap = (req_opcode == OP_DIV) && (req_b == 32'd0);
`else
  assign dz_trap = 1'b0;
`endif

  always_comb begin
    load_cnt = 6'd0;
    if (req_opcode == OP_MUL)      load_cnt = MUL_CNT;
    else if (req_opcode == OP_DIV) load_cnt = DIV_CNT;
  end

  // req_ready sees reset directly so nothing is offered as accepted during a reset cycle
  assign req_ready = (state == S_IDLE) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= 6'd0;
      alu_opcode <= 5'd0;
      alu_a      <= 32'd0;
      alu_b      <= 32'd0;
      z_high     <= 32'd0;
      z_low      <= 32'd0;
      illegal_op <= 1'b0;
      div_zero   <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (req_valid) begin
            alu_opcode <= req_opcode;
            alu_a      <= req_a;
            alu_b      <= req_b;
            illegal_op <= 1'b0;
            div_zero   <= 1'b0;
            busy       <= 1'b1;
            if (!legal) begin
              // illegal ops complete immediately and leave the previous result visible
              illegal_op <= 1'b1;
              state      <= S_DONE;
              done       <= 1'b1;
            end else if (dz_trap) begin
              div_zero <= 1'b1;
              z_high   <= 32'd0;
              z_low    <= 32'd0;
              state    <= S_DONE;
              done     <= 1'b1;
            end else begin
              cnt   <= load_cnt;
              state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          if (cnt == 6'd0) begin
            z_high <= alu_z[63:32];
            z_low  <= alu_z[31:0];
            state  <= S_DONE;
            done   <= 1'b1;
          end else begin
            cnt <= cnt - 6'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU, directed scenarios plus random ops
// checked against a transaction-level latency/result model.
module tb_alu_op_sequencer;
  localparam int MUL_L = 4;
  localparam int DIV_L = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_opcode;
  logic [31:0] req_a, req_b;
  logic [4:0]  alu_opcode;
  logic [31:0] alu_a, alu_b;
  logic [63:0] alu_z;
  logic [31:0] z_high, z_low;
  logic        done, busy, illegal_op, div_zero;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_zh = 32'd0;
  logic [31:0] exp_zl = 32'd0;
  bit trap_en;

  always #5 clk = ~clk;

  alu_op_sequencer #(.MUL_LATENCY(MUL_L), .DIV_LATENCY(DIV_L)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_z(alu_z),
    .z_high(z_high), .z_low(z_low), .done(done), .busy(busy),
    .illegal_op(illegal_op), .div_zero(div_zero)
  );

  function automatic logic [63:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    case (op)
      5'b01010: alu_fn = 64'(a) + 64'(b);
      5'b01011: alu_fn = {32'd0, a - b};
      5'b00110: alu_fn = {32'd0, a & b};
      5'b01100: alu_fn = sa * sb;
      5'b01101: alu_fn = (b == 32'd0) ? 64'hDEAD_BEEF_DEAD_BEEF : {a % b, a / b};
      default:  alu_fn = {a, a ^ b};
    endcase
  endfunction

  assign alu_z = alu_fn(alu_opcode, alu_a, alu_b);

  // Full transaction: accept, then check every cycle up to and one past done
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    bit ill, dz;
    int lat;
    logic [63:0] ez;
    ill = (op == 5'd0) || (op > 5'd13);
    dz  = trap_en && (op == 5'd13) && (b == 32'd0);
    if (ill || dz) lat = 1;
    else lat = ((op == 5'd12) ? MUL_L : (op == 5'd13) ? DIV_L : 1) + 1;
    ez = ill ? {exp_zh, exp_zl} : dz ? 64'd0 : alu_fn(op, a, b);
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_before op=%0h got=%b want=1", op, req_ready);
    end
    req_valid = 1'b1; req_opcode = op; req_a = a; req_b = b;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_opcode = 5'($urandom); req_a = $urandom; req_b = $urandom;
    for (int k = 1; k <= lat; k++) begin
      n_tests++;
      if (done !== (k == lat) || busy !== 1'b1 || req_ready !== 1'b0 ||
          alu_opcode !== op || alu_a !== a || alu_b !== b) begin
        n_fail++;
        $display("FAIL cycle op=%0h k=%0d got done=%b busy=%b rdy=%b alu=%0h/%h/%h want done=%b busy=1 rdy=0 alu=%0h/%h/%h",
                 op, k, done, busy, req_ready, alu_opcode, alu_a, alu_b, k == lat, op, a, b);
      end
      if (k < lat) @(negedge clk);
    end
    n_tests++;
    if ({z_high, z_low} !== ez || illegal_op !== ill || div_zero !== dz) begin
      n_fail++;
      $display("FAIL result op=%0h a=%h b=%h got z=%h ill=%b dz=%b want z=%h ill=%b dz=%b",
               op, a, b, {z_high, z_low}, illegal_op, div_zero, ez, ill, dz);
    end
    exp_zh = ez[63:32]; exp_zl = ez[31:0];
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || {z_high, z_low} !== ez) begin
      n_fail++;
      $display("FAIL after_done op=%0h got done=%b busy=%b rdy=%b z=%h want 0/0/1 z=%h",
               op, done, busy, req_ready, {z_high, z_low}, ez);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_opcode = 5'd0; req_a = 32'd0; req_b = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || alu_opcode !== 5'd0 ||
        alu_a !== 32'd0 || alu_b !== 32'd0 || z_high !== 32'd0 || z_low !== 32'd0 ||
        illegal_op !== 1'b0 || div_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state got rdy=%b busy=%b done=%b op=%0h a=%h b=%h z=%h ill=%b dz=%b want all 0",
               req_ready, busy, done, alu_opcode, alu_a, alu_b, {z_high, z_low}, illegal_op, div_zero);
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready got=%b want=1", req_ready);
    end
    exp_zh = 32'd0; exp_zl = 32'd0;
  endtask

  task automatic test_add();
    run_op(5'b01010, 32'd5, 32'd7);
    n_tests++;
    if (z_low !== 32'd12 || z_high !== 32'd0) begin
      n_fail++; $display("FAIL add_5_7 got %h_%h want 00000000_0000000c", z_high, z_low);
    end
  endtask

  task automatic test_mul();
    run_op(5'b01100, 32'hFFFF_FFFF, 32'd3);
    n_tests++;
    if (z_high !== 32'hFFFF_FFFF || z_low !== 32'hFFFF_FFFD) begin
      n_fail++; $display("FAIL mul_m1_3 got %h_%h want ffffffff_fffffffd", z_high, z_low);
    end
  endtask

  task automatic test_illegal();
    run_op(5'b01010, 32'd5, 32'd7);
    run_op(5'b11111, 32'h1234, 32'h5678);
    n_tests++;
    if (z_low !== 32'd12 || illegal_op !== 1'b1) begin
      n_fail++; $display("FAIL illegal_hold got z_low=%0d ill=%b want 12 1", z_low, illegal_op);
    end
    run_op(5'b00000, 32'd1, 32'd2);
    run_op(5'b01010, 32'd1, 32'd1);
    n_tests++;
    if (illegal_op !== 1'b0) begin
      n_fail++; $display("FAIL illegal_clear got=%b want=0", illegal_op);
    end
  endtask

  task automatic test_reset_in_exec();
    @(negedge clk);
    req_valid = 1'b1; req_opcode = 5'b01101; req_a = 32'd100; req_b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || z_high !== 32'd0 ||
        z_low !== 32'd0 || alu_a !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_exec got rdy=%b busy=%b done=%b z=%h a=%h want 1 0 0 0 0",
               req_ready, busy, done, {z_high, z_low}, alu_a);
    end
    exp_zh = 32'd0; exp_zl = 32'd0;
    for (int k = 0; k < DIV_L + 4; k++) begin
      @(negedge clk);
      n_tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL reset_exec_quiet k=%0d got done=%b busy=%b want 0 0", k, done, busy);
      end
    end
    run_op(5'b01010, 32'd20, 32'd22);
  endtask

  task automatic test_div_zero();
    run_op(5'b01101, 32'd100, 32'd7);
    run_op(5'b01101, 32'd55, 32'd0);
  endtask

  task automatic test_back_to_back();
    logic [63:0] e1, e2;
    e1 = alu_fn(5'b01011, 32'd50, 32'd8);
    e2 = alu_fn(5'b00110, 32'hF0F0, 32'hFF00);
    @(negedge clk);
    req_valid = 1'b1; req_opcode = 5'b01011; req_a = 32'd50; req_b = 32'd8;
    @(posedge clk);
    @(negedge clk);
    req_opcode = 5'b00110; req_a = 32'hF0F0; req_b = 32'hFF00;
    for (int k = 1; k <= 2; k++) begin
      n_tests++;
      if (alu_opcode !== 5'b01011 || alu_a !== 32'd50 || done !== (k == 2) || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_hold k=%0d got op=%0h a=%0d done=%b rdy=%b want 0b 50 %b 0",
                 k, alu_opcode, alu_a, done, req_ready, k == 2);
      end
      @(negedge clk);
    end
    n_tests++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || {z_high, z_low} !== e1) begin
      n_fail++; $display("FAIL b2b_idle got rdy=%b busy=%b z=%h want 1 0 %h", req_ready, busy, {z_high, z_low}, e1);
    end
    @(negedge clk);
    req_valid = 1'b0;
    n_tests++;
    if (alu_opcode !== 5'b00110 || alu_a !== 32'hF0F0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_accept got op=%0h a=%h busy=%b want 06 0000f0f0 1", alu_opcode, alu_a, busy);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b1 || {z_high, z_low} !== e2) begin
      n_fail++; $display("FAIL b2b_second got done=%b z=%h want 1 %h", done, {z_high, z_low}, e2);
    end
    exp_zh = e2[63:32]; exp_zl = e2[31:0];
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [4:0] op;
    logic [31:0] b;
    for (int i = 0; i < 40; i++) begin
      op = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 2) == 0) op = 5'($urandom_range(10, 13));
      b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      run_op(op, $urandom, b);
    end
  endtask

  initial begin
`ifdef ALU_DIV_ZERO_TRAP_EN
    trap_en = 1'b1;
`else
    trap_en = 1'b0;
`endif
    test_reset();
    test_add();
    test_mul();
    test_illegal();
    test_reset_in_exec();
    test_div_zero();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
